load_ext_ctrl: RTL and testbench
================================

Name: load_ext_ctrl

Overview:
Multi-cycle load sequencer for the CPU_31 memory stage.
- Accepts a load command (LW/LH/LHU/LB/LBU), checks alignment and issues a single word-aligned request to data memory.
- Waits for the memory acknowledge, then extracts the addressed byte or halfword and sign- or zero-extends it to 32 bits.
- Reports completion or an error code to the pipeline control.
- Sits between the execute-stage address output and the register-file write-back mux.

Parameters:
TIMEOUT, 16, number of cycles in REQ without mem_ack before the load aborts with a timeout error (minimum 2).
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  command strobe; sampled only in IDLE.
op  in  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU; 5..7 illegal.
addr  in  32  byte address of the load.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when result/err are valid.
result  out  32  extended load data; held until the next done.
err  out  2  0=none, 1=misaligned, 2=timeout, 3=illegal op; valid with done, held until the next done.
mem_req  out  1  memory request, held high until ack.
mem_addr  out  32  {addr_q[31:2],2'b00}, stable while mem_req is high.
mem_ack  in  1  memory acknowledge; mem_rdata is valid in the same cycle.
mem_rdata  in  32  little-endian word read data.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - busy=0, done=0, mem_req=0, result=0, err=0, mem_addr=0, timeout counter=0.
  - Reset mid-operation abandons the load; mem_req drops at that edge and no done is produced.
- States are IDLE, REQ, RESP, ERR.
- IDLE:
  - When start=1, latch op_q/addr_q.
  - Illegal op -> ERR with err=3.
  - Otherwise, if LW and addr[1:0]!=0, or LH/LHU and addr[0]!=0 -> ERR with err=1.
  - Otherwise -> REQ.
  - start=0 -> stay in IDLE.
- REQ:
  - mem_req=1, counter increments each cycle.
  - mem_ack=1 -> register the extended data into result, set err=0, go to RESP.
  - Counter reaches TIMEOUT-1 with no ack -> ERR with err=2.
  - If ack arrives on the same cycle the counter reaches TIMEOUT-1, the ack wins.
- RESP: done=1 for one cycle, then IDLE.
- ERR: done=1 for one cycle, result=0, then IDLE. mem_req is never asserted on the misaligned or illegal-op paths.
- Extraction (byte offset b = addr_q[1:0]):
  - LW: result = rdata.
  - LH/LHU: half = addr_q[1] ? rdata[31:16] : rdata[15:0]; LH sign-extends from bit 15, LHU zero-extends.
  - LB/LBU: byte = rdata[8b+7:8b]; LB sign-extends from bit 7, LBU zero-extends.
- Latency: start at cycle 0 -> REQ at cycle 1. An ack at cycle 1 gives done at cycle 2. Error paths give done at cycle 1.
- Ignored inputs:
  - start while busy=1 is ignored, not queued.
  - mem_ack outside REQ is ignored.
  - A new start in the RESP/ERR cycle is ignored; the earliest accepted start is the cycle after done.
- mem_addr and op_q stay stable for the whole REQ phase, even if addr/op inputs change.
- The counter clears on entry to REQ.

Decomposition:
- Package load_ext_pkg holds:
  - op encodings: OP_LW..OP_LBU;
  - err codes: ERR_NONE, ERR_ALIGN, ERR_TIMEOUT, ERR_OP;
  - the state enum.
- One combinational sub-module, subword_ext, with inputs rdata[31:0], off[1:0] and op[2:0] and output ext[31:0]. It performs extraction plus sign/zero extension and is reusable by the write-back path.
- The FSM, counter and registers live in load_ext_ctrl.

Test Plan:
- LH, addr=0x0000_1002, rdata=0x8001_1234, ack in first REQ cycle -> done at cycle 2, result=0xFFFF_8001, err=0, mem_addr=0x0000_1000.
- LHU at the same address and data -> result=0x0000_8001. LB addr=0x1003, rdata=0x80FF_0000 -> 0xFFFF_FF80. LBU -> 0x0000_0080.
- LW addr=0x1001 -> done at cycle 1, err=1, result=0, mem_req never high. LH addr=0x1003 gives the same response. op=6 -> err=3.
- TIMEOUT=4, no ack -> mem_req high for 4 cycles, then ERR: done with err=2, mem_req low. Ack on the 4th REQ cycle -> normal completion, err=0.
- start pulsed on every cycle during a 3-cycle ack delay -> only the first command executes; exactly one done, then IDLE.
- rst_n low for one cycle during REQ -> next cycle busy=0, mem_req=0, no done. A later ack pulse is ignored and result stays 0.

Source files
------------

// File: rtl/load_ext_pkg.sv
// Shared definitions for the load sequencer: op and error encodings, FSM state
// type and alignment helpers.
package load_ext_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OP      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    function automatic logic op_illegal(input logic [2:0] op);
        return (op > OP_LBU);
    endfunction

    // Words need a 4-byte boundary, halfwords a 2-byte boundary, bytes any.
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LW:         bad = (off != 2'b00);
            OP_LH, OP_LHU: bad = off[0];
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_ext_ctrl_if.sv
// Command/response and data-memory signals of the load sequencer.
// slave is the sequencer side, master is the pipeline/memory side.
interface load_ext_ctrl_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  start, op, addr, mem_ack, mem_rdata,
        output busy, done, result, err, mem_req, mem_addr
    );

    modport master (
        output start, op, addr, mem_ack, mem_rdata,
        input  busy, done, result, err, mem_req, mem_addr
    );

endinterface

// File: rtl/load_ext_ctrl_subword_ext.sv
// Selects the addressed byte/halfword of a little-endian word and sign- or
// zero-extends it to 32 bits. Purely combinational.
module subword_ext
    import load_ext_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  op,
    output logic [31:0] ext
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    // Lane selection followed by extension according to the op.
    always_comb begin
        half   = off[1] ? rdata[31:16] : rdata[15:0];
        byte_v = 8'h00;
        case (off)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = 8'h00;
        endcase
        ext = 32'h0;
        case (op)
            OP_LW:   ext = rdata;
            OP_LH:   ext = {{16{half[15]}}, half};
            OP_LHU:  ext = {16'h0, half};
            OP_LB:   ext = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  ext = {24'h0, byte_v};
            default: ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_ext_ctrl.sv
// Multi-cycle load sequencer: alignment/op check, one word-aligned memory
// request with timeout, then sub-word extraction of the returned data.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for start; only state in which start is sampled
//  ST_REQ  | mem_req high, waiting for mem_ack, timeout counter running
//  ST_RESP | done pulse with extracted result, err = none
//  ST_ERR  | done pulse with result = 0 and an error code
module load_ext_ctrl
    import load_ext_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic            clk,
    input logic            rst_n,
    load_ext_ctrl_if.slave bus
);

    state_t            state;
    logic [2:0]        op_q;
    logic [31:0]       addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       ext;
    logic              busy_q;
    logic              done_q;
    logic              mem_req_q;
    logic [31:0]       result_q;
    logic [1:0]        err_q;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    subword_ext u_ext (
        .rdata (bus.mem_rdata),
        .off   (addr_q[1:0]),
        .op    (op_q),
        .ext   (ext)
    );

    // addr_q only changes in IDLE, so the request address is frozen during REQ.
    assign bus.mem_addr = {addr_q[31:2], 2'b00};
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.result   = result_q;
    assign bus.err      = err_q;

    // Sequencer FSM with registered outputs; done is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= 3'd0;
            addr_q    <= 32'h0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mem_req_q <= 1'b0;
            result_q  <= 32'h0;
            err_q     <= ERR_NONE;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        addr_q <= bus.addr;
                        busy_q <= 1'b1;
                        if (op_illegal(bus.op)) begin
                            state    <= ST_ERR;
                            err_q    <= ERR_OP;
                            result_q <= 32'h0;
                            done_q   <= 1'b1;
                        end else if (misaligned(bus.op, bus.addr[1:0])) begin
                            state    <= ST_ERR;
                            err_q    <= ERR_ALIGN;
                            result_q <= 32'h0;
                            done_q   <= 1'b1;
                        end else begin
                            state     <= ST_REQ;
                            mem_req_q <= 1'b1;
                            cnt_q     <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a timeout on the same cycle.
                    if (bus.mem_ack) begin
                        state     <= ST_RESP;
                        mem_req_q <= 1'b0;
                        result_q  <= ext;
                        err_q     <= ERR_NONE;
                        done_q    <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state     <= ST_ERR;
                        mem_req_q <= 1'b0;
                        result_q  <= 32'h0;
                        err_q     <= ERR_TIMEOUT;
                        done_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP, ST_ERR: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Directed bench for load_ext_ctrl with a scoreboard of expected completions.
module tb_load_ext_ctrl;
    import load_ext_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  err;
        int          lat;
        int          reqs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    load_ext_ctrl_if bus();

    load_ext_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ack_cycle: REQ cycle (1-based) in which mem_ack is driven, 0 = never.
    // spam: keep start high with changing op/addr until done is seen.
    task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] rdata, input int ack_cycle,
                            input logic [31:0] exp_res, input logic [1:0] exp_err,
                            input int exp_lat, input int exp_reqs, input bit spam);
        exp_t        e;
        int          cyc;
        int          reqs;
        int          lat;
        bit          seen;
        logic [31:0] exp_maddr;
        e.res = exp_res;
        e.err = exp_err;
        e.lat = exp_lat;
        e.reqs = exp_reqs;
        sb.push_back(e);
        exp_maddr = {addr[31:2], 2'b00};
        bus.start = 1'b1;
        bus.op = op;
        bus.addr = addr;
        bus.mem_ack = 1'b0;
        step();
        cyc = 1;
        reqs = 0;
        lat = -1;
        seen = 1'b0;
        if (!spam) bus.start = 1'b0;
        while (cyc < 40 && !seen) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat = cyc;
                bus.start = 1'b0;
                bus.mem_ack = 1'b0;
            end else begin
                if (bus.mem_req === 1'b1) begin
                    reqs++;
                    chk($sformatf("%s_mem_addr", tag), bus.mem_addr, exp_maddr);
                    if (reqs == ack_cycle) begin
                        bus.mem_ack = 1'b1;
                        bus.mem_rdata = rdata;
                    end else begin
                        bus.mem_ack = 1'b0;
                        bus.mem_rdata = $urandom;
                    end
                end else begin
                    bus.mem_ack = 1'b0;
                end
                if (spam) begin
                    bus.op = 3'($urandom_range(0, 7));
                    bus.addr = $urandom;
                end
                step();
                cyc++;
            end
        end
        chk($sformatf("%s_done_seen", tag), 32'(seen), 32'd1);
        e = sb.pop_front();
        chk($sformatf("%s_result", tag), bus.result, e.res);
        chk($sformatf("%s_err", tag), 32'(bus.err), 32'(e.err));
        chk($sformatf("%s_latency", tag), 32'(lat), 32'(e.lat));
        chk($sformatf("%s_req_cycles", tag), 32'(reqs), 32'(e.reqs));
        step();
        chk($sformatf("%s_done_pulse", tag), 32'(bus.done), 32'd0);
        chk($sformatf("%s_idle_after", tag), 32'(bus.busy), 32'd0);
        chk($sformatf("%s_result_held", tag), bus.result, e.res);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.addr = 32'h0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        rst_n = 1'b1;
        step();

        run_load("lh",      OP_LH,  32'h0000_1002, 32'h8001_1234, 1, 32'hFFFF_8001, ERR_NONE, 2, 1, 1'b0);
        run_load("lhu",     OP_LHU, 32'h0000_1002, 32'h8001_1234, 1, 32'h0000_8001, ERR_NONE, 2, 1, 1'b0);
        run_load("lb",      OP_LB,  32'h0000_1003, 32'h80FF_0000, 1, 32'hFFFF_FF80, ERR_NONE, 2, 1, 1'b0);
        run_load("lbu",     OP_LBU, 32'h0000_1003, 32'h80FF_0000, 1, 32'h0000_0080, ERR_NONE, 2, 1, 1'b0);
        run_load("lw",      OP_LW,  32'h0000_1004, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, ERR_NONE, 3, 2, 1'b0);
        run_load("lh_lo",   OP_LH,  32'h0000_1000, 32'h8001_7FFF, 1, 32'h0000_7FFF, ERR_NONE, 2, 1, 1'b0);
        run_load("lb_b2",   OP_LB,  32'h0000_1002, 32'h80FF_0000, 1, 32'hFFFF_FFFF, ERR_NONE, 2, 1, 1'b0);
        run_load("lbu_b1",  OP_LBU, 32'h0000_1001, 32'h1234_5680, 3, 32'h0000_0056, ERR_NONE, 4, 3, 1'b0);
        run_load("lw_mis",  OP_LW,  32'h0000_1001, 32'h1111_1111, 1, 32'h0, ERR_ALIGN, 1, 0, 1'b0);
        run_load("lh_mis",  OP_LH,  32'h0000_1003, 32'h1111_1111, 1, 32'h0, ERR_ALIGN, 1, 0, 1'b0);
        run_load("lhu_mis", OP_LHU, 32'h0000_1001, 32'h1111_1111, 1, 32'h0, ERR_ALIGN, 1, 0, 1'b0);
        run_load("lbu_ok",  OP_LBU, 32'h0000_1000, 32'h0000_00C3, 1, 32'h0000_00C3, ERR_NONE, 2, 1, 1'b0);
        run_load("op6",     3'd6,   32'h0000_1000, 32'h1111_1111, 1, 32'h0, ERR_OP, 1, 0, 1'b0);
        run_load("op5_odd", 3'd5,   32'h0000_1001, 32'h1111_1111, 1, 32'h0, ERR_OP, 1, 0, 1'b0);
        run_load("lw_ok",   OP_LW,  32'h0000_2000, 32'h7654_3210, 1, 32'h7654_3210, ERR_NONE, 2, 1, 1'b0);
        run_load("tmo",     OP_LW,  32'h0000_2000, 32'h0, 0, 32'h0, ERR_TIMEOUT, 5, 4, 1'b0);
        run_load("ack_last", OP_LW, 32'h0000_2000, 32'hCAFE_F00D, 4, 32'hCAFE_F00D, ERR_NONE, 5, 4, 1'b0);
        run_load("spam",    OP_LBU, 32'h0000_3002, 32'h00A5_0000, 4, 32'h0000_00A5, ERR_NONE, 5, 4, 1'b1);

        // Reset in the middle of REQ abandons the load.
        bus.start = 1'b1;
        bus.op = OP_LW;
        bus.addr = 32'h0000_4000;
        step();
        bus.start = 1'b0;
        chk("rstmid_req_up", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rstmid_done", 32'(bus.done), 32'd0);
        chk("rstmid_result", bus.result, 32'h0);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1111_1111;
        step();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stray_ack_done_%0d", i), 32'(bus.done), 32'd0);
            chk($sformatf("stray_ack_result_%0d", i), bus.result, 32'h0);
            chk($sformatf("stray_ack_busy_%0d", i), 32'(bus.busy), 32'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
